// File: rtl/sha512_pkg.sv
// sha512_pkg: shared definitions for the SHA-512 hash controller.
//   state_t         controller FSM state encoding
//   ROUNDS_DEFAULT  compression rounds per 1024-bit block
//   SHA512_IV       initial hash values H0..H7 selected by the H-register input mux
//   iv_word()       indexed lookup into SHA512_IV
package sha512_pkg;

    localparam int unsigned ROUNDS_DEFAULT = 80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_H,
        ST_WAIT_BLK,
        ST_LOAD_WV,
        ST_ROUND,
        ST_FEED,
        ST_DONE
    } state_t;

    localparam logic [63:0] SHA512_IV [8] = '{
        64'h6a09e667f3bcc908,
        64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b,
        64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1,
        64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b,
        64'h5be0cd19137e2179
    };

    function automatic logic [63:0] iv_word(input logic [2:0] idx);
        return SHA512_IV[idx];
    endfunction

endpackage

// File: rtl/sha_round_counter.sv
// sha_round_counter: round index counter for the compression loop.
//   clk    in   clock
//   rst    in   synchronous active-high reset (count -> 0)
//   clr    in   synchronous clear (count -> 0)
//   en     in   advance one round; wraps to 0 after ROUNDS-1
//   count  out  current round index
//   tc     out  terminal count, high while count == ROUNDS-1
module sha_round_counter
    import sha512_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned RIDX_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [RIDX_W-1:0] count,
    output logic              tc
);

    localparam logic [RIDX_W-1:0] LAST = RIDX_W'(ROUNDS - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            // Never passes ROUNDS-1: the terminal round returns to 0.
            count <= tc ? '0 : count + RIDX_W'(1);
        end
    end

endmodule

// File: rtl/sha512_hash_ctrl.sv
// sha512_hash_ctrl: sequencer for the SHA-512 compression datapath.
//   CLK, RST      clock / synchronous active-high reset
//   start         begin a new message (IV load), honoured only when idle
//   blk_valid     message front-end offers a 1024-bit block
//   blk_last      the offered block is the final one
//   blk_ready     block accepted this cycle (waiting for a block)
//   wt_valid      schedule word W_t for round_idx is available
//   round_idx     current round t, 0 outside the round loop
//   wv_load       load working variables a..h from H
//   wv_en         apply one compression round to a..h
//   h_load        load strobe for all eight H registers
//   h_sel_iv      H input mux: 1 = IV constants, 0 = H + working vars
//   busy          controller not idle
//   digest_valid  one-cycle pulse, H now holds the final digest
// All outputs are a combinational decode of the state register (plus wt_valid
// for wv_en), so every strobe is zero whenever the FSM sits in IDLE.
module sha512_hash_ctrl
    import sha512_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned RIDX_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              blk_valid,
    input  logic              blk_last,
    output logic              blk_ready,
    input  logic              wt_valid,
    output logic [RIDX_W-1:0] round_idx,
    output logic              wv_load,
    output logic              wv_en,
    output logic              h_load,
    output logic              h_sel_iv,
    output logic              busy,
    output logic              digest_valid
);

    state_t            state;
    logic              last_flag;
    logic [RIDX_W-1:0] count;
    logic              tc;
    logic              in_round;
    logic              cnt_clr;
    logic              cnt_en;

    assign in_round = (state == ST_ROUND);
    assign cnt_clr  = (state == ST_LOAD_WV);
    assign cnt_en   = in_round && wt_valid;

    sha_round_counter #(
        .ROUNDS (ROUNDS),
        .RIDX_W (RIDX_W)
    ) u_round_counter (
        .clk   (CLK),
        .rst   (RST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            last_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_INIT_H;
                end
                ST_INIT_H: state <= ST_WAIT_BLK;
                ST_WAIT_BLK: begin
                    if (blk_valid) begin
                        last_flag <= blk_last;
                        state     <= ST_LOAD_WV;
                    end
                end
                ST_LOAD_WV: state <= ST_ROUND;
                ST_ROUND: begin
                    // The counter wraps to 0 on this same edge.
                    if (wt_valid && tc) state <= ST_FEED;
                end
                ST_FEED: state <= last_flag ? ST_DONE : ST_WAIT_BLK;
                ST_DONE: begin
                    last_flag <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        blk_ready    = 1'b0;
        wv_load      = 1'b0;
        wv_en        = 1'b0;
        h_load       = 1'b0;
        h_sel_iv     = 1'b0;
        digest_valid = 1'b0;
        round_idx    = '0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_INIT_H: begin
                h_load   = 1'b1;
                h_sel_iv = 1'b1;
            end
            ST_WAIT_BLK: blk_ready = 1'b1;
            ST_LOAD_WV:  wv_load   = 1'b1;
            ST_ROUND: begin
                wv_en     = wt_valid;
                round_idx = count;
            end
            ST_FEED:     h_load       = 1'b1;
            ST_DONE:     digest_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha512_hash_ctrl.sv
// tb_sha512_hash_ctrl: directed bench for sha512_hash_ctrl.
// Stimulus is a table of phases {cycles, inputs, expected outputs, expected
// round_idx start and whether it advances per cycle}, followed by a hand-written
// mid-round reset sequence. A negedge monitor checks the per-cycle invariants.
module tb_sha512_hash_ctrl;
    import sha512_pkg::*;

    // Output bit order: {blk_ready, wv_load, wv_en, h_load, h_sel_iv, busy, digest_valid}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_INIT  = 7'b0001110;
    localparam logic [6:0] O_WAIT  = 7'b1000010;
    localparam logic [6:0] O_LOAD  = 7'b0100010;
    localparam logic [6:0] O_REN   = 7'b0010010;
    localparam logic [6:0] O_RSTL  = 7'b0000010;
    localparam logic [6:0] O_FEED  = 7'b0001010;
    localparam logic [6:0] O_DONE  = 7'b0000011;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start, blk_valid, blk_last, wt_valid;
    logic       blk_ready, wv_load, wv_en, h_load, h_sel_iv, busy, digest_valid;
    logic [6:0] round_idx;
    logic [6:0] outs;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        mon_en = 1'b0;

    // Input bit order: {start, blk_valid, blk_last, wt_valid}
    typedef struct {
        int unsigned ncyc;
        logic [3:0]  in;
        logic [6:0]  outs;
        int unsigned ridx;
        logic        ridx_inc;
    } vec_t;

    vec_t vq[$];

    always #5 CLK = ~CLK;

    assign outs = {blk_ready, wv_load, wv_en, h_load, h_sel_iv, busy, digest_valid};

    sha512_hash_ctrl #(
        .ROUNDS (80),
        .RIDX_W (7)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .blk_valid    (blk_valid),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .wt_valid     (wt_valid),
        .round_idx    (round_idx),
        .wv_load      (wv_load),
        .wv_en        (wv_en),
        .h_load       (h_load),
        .h_sel_iv     (h_sel_iv),
        .busy         (busy),
        .digest_valid (digest_valid)
    );

    function automatic void add(input int unsigned n, input logic [3:0] in,
                                input logic [6:0] o, input int unsigned r, input logic inc);
        vec_t v;
        v.ncyc = n; v.in = in; v.outs = o; v.ridx = r; v.ridx_inc = inc;
        vq.push_back(v);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] in);
        {start, blk_valid, blk_last, wt_valid} = in;
    endtask

    task automatic check(input string name, input logic [6:0] exp_o, input logic [6:0] exp_r);
        checks++;
        if (outs !== exp_o) begin
            errors++;
            $display("FAIL %s outs got=%b exp=%b", name, outs, exp_o);
        end
        checks++;
        if (round_idx !== exp_r) begin
            errors++;
            $display("FAIL %s round_idx got=%0d exp=%0d", name, round_idx, exp_r);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            checks++;
            if ($countones({wv_load, wv_en, h_load}) > 1) begin
                errors++;
                $display("FAIL onehot {wv_load,wv_en,h_load} got=%b exp=at most one", {wv_load, wv_en, h_load});
            end
            checks++;
            if (round_idx >= 7'd80) begin
                errors++;
                $display("FAIL ridx_range got=%0d exp=<80", round_idx);
            end
            checks++;
            if (busy !== (dut.state != ST_IDLE)) begin
                errors++;
                $display("FAIL busy_state got=%b exp=%b", busy, dut.state != ST_IDLE);
            end
            checks++;
            if (h_sel_iv && !h_load) begin
                errors++;
                $display("FAIL h_sel_iv_gate got=%b exp=0", h_sel_iv);
            end
        end
    end

    initial begin
        // Single block, wt_valid tied 1: digest_valid at cycle 85, IDLE at 86.
        add(1,  4'b1001, O_IDLE, 0, 1'b0);
        add(1,  4'b0001, O_INIT, 0, 1'b0);
        add(1,  4'b0111, O_WAIT, 0, 1'b0);
        add(1,  4'b0001, O_LOAD, 0, 1'b0);
        add(80, 4'b0001, O_REN,  0, 1'b1);
        add(1,  4'b0001, O_FEED, 0, 1'b0);
        add(1,  4'b0001, O_DONE, 0, 1'b0);
        add(1,  4'b0001, O_IDLE, 0, 1'b0);
        // Schedule stall of 3 cycles at t=10: digest_valid slips to cycle 88.
        add(1,  4'b1000, O_IDLE, 0,  1'b0);
        add(1,  4'b0000, O_INIT, 0,  1'b0);
        add(1,  4'b0110, O_WAIT, 0,  1'b0);
        add(1,  4'b0000, O_LOAD, 0,  1'b0);
        add(10, 4'b0001, O_REN,  0,  1'b1);
        add(3,  4'b0000, O_RSTL, 10, 1'b0);
        add(70, 4'b0001, O_REN,  10, 1'b1);
        add(1,  4'b0000, O_FEED, 0,  1'b0);
        add(1,  4'b0000, O_DONE, 0,  1'b0);
        add(1,  4'b0000, O_IDLE, 0,  1'b0);
        // Two blocks with start / blk_valid pulses where they must be ignored.
        add(1,  4'b1000, O_IDLE, 0, 1'b0);
        add(1,  4'b0000, O_INIT, 0, 1'b0);
        add(1,  4'b1000, O_WAIT, 0, 1'b0);
        add(1,  4'b0000, O_WAIT, 0, 1'b0);
        add(1,  4'b0100, O_WAIT, 0, 1'b0);
        add(1,  4'b0000, O_LOAD, 0, 1'b0);
        add(5,  4'b0001, O_REN,  0, 1'b1);
        add(1,  4'b1001, O_REN,  5, 1'b0);
        add(1,  4'b0111, O_REN,  6, 1'b0);
        add(73, 4'b0001, O_REN,  7, 1'b1);
        add(1,  4'b0000, O_FEED, 0, 1'b0);
        add(1,  4'b0000, O_WAIT, 0, 1'b0);
        add(1,  4'b0110, O_WAIT, 0, 1'b0);
        add(1,  4'b0000, O_LOAD, 0, 1'b0);
        add(80, 4'b0001, O_REN,  0, 1'b1);
        add(1,  4'b0000, O_FEED, 0, 1'b0);
        add(1,  4'b0000, O_DONE, 0, 1'b0);
        add(2,  4'b0000, O_IDLE, 0, 1'b0);

        RST = 1'b1;
        drive(4'b0000);
        tick();
        tick();
        check("reset_hold", O_IDLE, 7'd0);
        RST = 1'b0;
        mon_en = 1'b1;

        foreach (vq[i]) begin
            for (int unsigned k = 0; k < vq[i].ncyc; k++) begin
                drive(vq[i].in);
                #1;
                check($sformatf("vec%0d_cyc%0d", i, k), vq[i].outs,
                      7'(vq[i].ridx + (vq[i].ridx_inc ? k : 0)));
                tick();
            end
        end

        // Reset asserted for two cycles while round_idx is 37.
        drive(4'b1001); tick();
        drive(4'b0001); tick();
        drive(4'b0111); tick();
        drive(4'b0001); tick();
        repeat (37) tick();
        #1;
        check("pre_reset_r37", O_REN, 7'd37);
        RST = 1'b1;
        tick();
        check("reset_mid1", O_IDLE, 7'd0);
        tick();
        RST = 1'b0;
        drive(4'b0000);
        #1;
        check("post_reset_idle", O_IDLE, 7'd0);
        tick();
        check("post_reset_stay", O_IDLE, 7'd0);
        drive(4'b1000);
        tick();
        drive(4'b0000);
        #1;
        check("post_reset_init", O_INIT, 7'd0);
        tick();
        check("post_reset_wait", O_WAIT, 7'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
